// File: rtl/router_req_issuer.sv
// Route-request issuer: captures A/B words, issues them as a pair to the decision logic,
// delivers grants A-then-B and backs off or drops on refusal. ROUTER_REQ_TIMEOUT_EN adds a WAIT watchdog.
//   state   | meaning
//   IDLE    | ready for capture from A and/or B
//   ISSUE   | one-cycle req_valid_o strobe
//   WAIT    | holding request words, awaiting decision
//   BACKOFF | idle countdown before re-issue
//   DELIVER | presenting granted words downstream
module router_req_issuer #(
    parameter int W         = 30,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid_i,
    input  logic [W-1:0] a_data_i,
    output logic         a_ready_o,
    input  logic         b_valid_i,
    input  logic [W-1:0] b_data_i,
    output logic         b_ready_o,
    output logic [W-1:0] req_a_o,
    output logic [W-1:0] req_b_o,
    output logic         req_valid_o,
    input  logic         dec_valid_i,
    input  logic [2:0]   dec_i,
    output logic         gnt_valid_o,
    output logic         gnt_port_o,
    output logic [W-1:0] gnt_data_o,
    input  logic         gnt_ready_i,
    output logic         drop_o,
    output logic         busy_o
);
    localparam int RW = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
    localparam int BW = ($clog2(BACKOFF) < 1) ? 1 : $clog2(BACKOFF);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF, S_DELIVER} state_t;

    state_t        state;
    logic          pend_a, pend_b, gnt_b;
    logic [RW-1:0] retry_cnt, retry_nxt;
    logic [BW-1:0] bo_cnt;
    logic          eff_a, eff_b, capture, retry_ev, wd_exp;

`ifdef ROUTER_REQ_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
    logic [TW-1:0] wd_cnt;
    assign wd_exp = (state == S_WAIT) && (wd_cnt == '0);
`else
    assign wd_exp = 1'b0;
`endif

    // grant bits only count for ports that are actually pending
    assign eff_a     = dec_i[0] & pend_a;
    assign eff_b     = dec_i[1] & pend_b;
    assign capture   = (a_valid_i | b_valid_i) & a_ready_o;
    assign retry_ev  = dec_valid_i | wd_exp;
    assign retry_nxt = retry_cnt + RW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
            gnt_b       <= 1'b0;
            retry_cnt   <= '0;
            bo_cnt      <= '0;
            a_ready_o   <= 1'b0;
            b_ready_o   <= 1'b0;
            req_a_o     <= '0;
            req_b_o     <= '0;
            req_valid_o <= 1'b0;
            gnt_valid_o <= 1'b0;
            gnt_port_o  <= 1'b0;
            gnt_data_o  <= '0;
            drop_o      <= 1'b0;
            busy_o      <= 1'b0;
`ifdef ROUTER_REQ_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            req_valid_o <= 1'b0;
            drop_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        pend_a      <= a_valid_i;
                        pend_b      <= b_valid_i;
                        req_a_o     <= a_valid_i ? a_data_i : '0;
                        req_b_o     <= b_valid_i ? b_data_i : '0;
                        retry_cnt   <= '0;
                        a_ready_o   <= 1'b0;
                        b_ready_o   <= 1'b0;
                        busy_o      <= 1'b1;
                        req_valid_o <= 1'b1;
                        state       <= S_ISSUE;
                    end else begin
                        a_ready_o <= 1'b1;
                        b_ready_o <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef ROUTER_REQ_TIMEOUT_EN
                    wd_cnt <= TW'(TIMEOUT - 1);
`endif
                end
                S_WAIT: begin
                    if (dec_valid_i && (eff_a || eff_b)) begin
                        retry_cnt   <= '0;
                        gnt_b       <= eff_b;
                        gnt_valid_o <= 1'b1;
                        gnt_port_o  <= ~eff_a;
                        gnt_data_o  <= eff_a ? req_a_o : req_b_o;
                        state       <= S_DELIVER;
                    end else if (retry_ev) begin
                        if (retry_nxt == RW'(MAX_RETRY)) begin
                            pend_a    <= 1'b0;
                            pend_b    <= 1'b0;
                            req_a_o   <= '0;
                            req_b_o   <= '0;
                            retry_cnt <= '0;
                            drop_o    <= 1'b1;
                            busy_o    <= 1'b0;
                            a_ready_o <= 1'b1;
                            b_ready_o <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            retry_cnt <= retry_nxt;
                            bo_cnt    <= BW'(BACKOFF - 1);
                            state     <= S_BACKOFF;
                        end
                    end
`ifdef ROUTER_REQ_TIMEOUT_EN
                    else begin
                        wd_cnt <= wd_cnt - TW'(1);
                    end
`endif
                end
                S_BACKOFF: begin
                    if (bo_cnt == '0) begin
                        req_valid_o <= 1'b1;
                        state       <= S_ISSUE;
                    end else begin
                        bo_cnt <= bo_cnt - BW'(1);
                    end
                end
                S_DELIVER: begin
                    if (gnt_ready_i) begin
                        if (!gnt_port_o) begin
                            pend_a  <= 1'b0;
                            req_a_o <= '0;
                        end else begin
                            pend_b  <= 1'b0;
                            req_b_o <= '0;
                        end
                        if (!gnt_port_o && gnt_b) begin
                            gnt_port_o <= 1'b1;
                            gnt_data_o <= req_b_o;
                        end else begin
                            gnt_valid_o <= 1'b0;
                            gnt_port_o  <= 1'b0;
                            gnt_data_o  <= '0;
                            gnt_b       <= 1'b0;
                            // an ungranted port still pending gets re-issued on its own
                            if ((pend_a && gnt_port_o) || (pend_b && !gnt_port_o)) begin
                                req_valid_o <= 1'b1;
                                state       <= S_ISSUE;
                            end else begin
                                busy_o    <= 1'b0;
                                a_ready_o <= 1'b1;
                                b_ready_o <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_req_issuer.sv
// Bench for router_req_issuer: directed scenarios then random transactions checked
// against a transaction-level model of pending ports, grants, retries and drops.
module tb_router_req_issuer;
    localparam int W         = 30;
    localparam int MAX_RETRY = 3;
    localparam int BACKOFF   = 4;
    localparam int TIMEOUT   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid_i, b_valid_i;
    logic [W-1:0] a_data_i, b_data_i;
    logic         a_ready_o, b_ready_o;
    logic [W-1:0] req_a_o, req_b_o;
    logic         req_valid_o;
    logic         dec_valid_i;
    logic [2:0]   dec_i;
    logic         gnt_valid_o, gnt_port_o;
    logic [W-1:0] gnt_data_o;
    logic         gnt_ready_i;
    logic         drop_o, busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int dec_q[$];
    int stall_fix = -1;

    router_req_issuer #(.W(W), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .req_a_o(req_a_o), .req_b_o(req_b_o), .req_valid_o(req_valid_o),
        .dec_valid_i(dec_valid_i), .dec_i(dec_i),
        .gnt_valid_o(gnt_valid_o), .gnt_port_o(gnt_port_o), .gnt_data_o(gnt_data_o),
        .gnt_ready_i(gnt_ready_i), .drop_o(drop_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk1({tag, "_a_ready"}, a_ready_o, 1'b0);
        chk1({tag, "_b_ready"}, b_ready_o, 1'b0);
        chkw({tag, "_req_a"}, req_a_o, '0);
        chkw({tag, "_req_b"}, req_b_o, '0);
        chk1({tag, "_req_valid"}, req_valid_o, 1'b0);
        chk1({tag, "_gnt_valid"}, gnt_valid_o, 1'b0);
        chk1({tag, "_gnt_port"}, gnt_port_o, 1'b0);
        chkw({tag, "_gnt_data"}, gnt_data_o, '0);
        chk1({tag, "_drop"}, drop_o, 1'b0);
        chk1({tag, "_busy"}, busy_o, 1'b0);
    endtask

    // One request pair from capture to completion (all delivered or dropped).
    // Decisions come from dec_q when it is non-empty, otherwise random.
    task automatic run_txn(input logic va, input logic vb, input logic [W-1:0] da, input logic [W-1:0] db);
        logic         pa, pb, ea, eb, done;
        logic [W-1:0] held;
        int           retries, d, st, wt;
        pa = va; pb = vb; retries = 0; done = 1'b0;
        chk1("cap_ready", a_ready_o, 1'b1);
        a_valid_i = va; b_valid_i = vb; a_data_i = da; b_data_i = db;
        tick();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        a_data_i = W'($urandom); b_data_i = W'($urandom);
        for (int it = 0; it < 12 && !done; it++) begin
            chk1("issue_valid", req_valid_o, 1'b1);
            chkw("issue_req_a", req_a_o, pa ? da : '0);
            chkw("issue_req_b", req_b_o, pb ? db : '0);
            chk1("issue_busy", busy_o, 1'b1);
            if (dec_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                dec_valid_i = 1'b1;
                dec_i = 3'($urandom);
            end
            tick();
            dec_valid_i = 1'b0;
            wt = (dec_q.size() != 0) ? 0 : int'($urandom_range(0, 2));
            for (int k = 0; k < wt; k++) begin
                chk1("wait_no_issue", req_valid_o, 1'b0);
                tick();
            end
            chk1("wait_no_issue", req_valid_o, 1'b0);
            chkw("wait_hold_a", req_a_o, pa ? da : '0);
            chkw("wait_hold_b", req_b_o, pb ? db : '0);
            d = (dec_q.size() != 0) ? dec_q.pop_front() : int'($urandom_range(0, 7));
            dec_valid_i = 1'b1;
            dec_i = d[2:0];
            tick();
            dec_valid_i = 1'b0;
            dec_i = 3'($urandom);
            ea = d[0] && pa;
            eb = d[1] && pb;
            if (ea || eb) begin
                retries = 0;
                for (int p = 0; p < 2; p++) begin
                    if ((p == 0 && ea) || (p == 1 && eb)) begin
                        held = (p == 0) ? da : db;
                        st = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
                        for (int k = 0; k <= st; k++) begin
                            chk1("gnt_valid", gnt_valid_o, 1'b1);
                            chk1("gnt_port", gnt_port_o, p[0]);
                            chkw("gnt_data", gnt_data_o, held);
                            chk1("gnt_no_drop", drop_o, 1'b0);
                            if (k == st) gnt_ready_i = 1'b1;
                            tick();
                        end
                        gnt_ready_i = 1'b0;
                        if (p == 0) pa = 1'b0; else pb = 1'b0;
                    end
                end
                chk1("post_gnt_valid", gnt_valid_o, 1'b0);
                chk1("post_gnt_drop", drop_o, 1'b0);
                if (!pa && !pb) begin
                    chk1("done_busy", busy_o, 1'b0);
                    chk1("done_ready", a_ready_o, 1'b1);
                    done = 1'b1;
                end
            end else begin
                retries++;
                if (retries == MAX_RETRY) begin
                    chk1("drop_pulse", drop_o, 1'b1);
                    chk1("drop_busy", busy_o, 1'b0);
                    chk1("drop_ready", b_ready_o, 1'b1);
                    chkw("drop_req_a", req_a_o, '0);
                    tick();
                    chk1("drop_single", drop_o, 1'b0);
                    done = 1'b1;
                end else begin
                    for (int k = 0; k < BACKOFF; k++) begin
                        chk1("backoff_quiet", req_valid_o, 1'b0);
                        chk1("backoff_busy", busy_o, 1'b1);
                        chk1("backoff_no_drop", drop_o, 1'b0);
                        tick();
                    end
                end
            end
        end
        chk1("txn_complete", done, 1'b1);
    endtask

    initial begin
        int seen, cnt;
        logic va, vb;
        rst = 1'b1;
        a_valid_i = 1'b0; b_valid_i = 1'b0; a_data_i = '0; b_data_i = '0;
        dec_valid_i = 1'b0; dec_i = '0; gnt_ready_i = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        chk1("post_reset_a_ready", a_ready_o, 1'b1);
        chk1("post_reset_b_ready", b_ready_o, 1'b1);
        chk1("post_reset_busy", busy_o, 1'b0);

        // single A, immediate grant
        dec_q = '{1}; stall_fix = 0;
        run_txn(1'b1, 1'b0, 30'h2AAAAAAA, 30'h0000_1555);
        // both, double grant with 3 stall cycles on A
        dec_q = '{3}; stall_fix = 3;
        run_txn(1'b1, 1'b1, 30'h1234_5678, 30'h0ABC_DEF0);
        // B only granted, then A on re-issue
        dec_q = '{2, 1}; stall_fix = 0;
        run_txn(1'b1, 1'b1, 30'h3000_0001, 30'h0FFF_FFFE);
        // three retries drop the pair
        dec_q = '{4, 4, 4};
        run_txn(1'b1, 1'b1, 30'h1111_1111, 30'h2222_2222);
        // grant to a non-pending port counts as retry
        dec_q = '{2, 0, 1};
        run_txn(1'b1, 1'b0, 30'h0555_0555, 30'h3FFF_FFFF);
        // retries then grant: counter clears on grant
        dec_q = '{4, 4, 2, 4, 4, 1};
        run_txn(1'b1, 1'b1, 30'h0000_0001, 30'h2000_0000);

        chk1("wd_ready", a_ready_o, 1'b1);
        a_valid_i = 1'b1; a_data_i = 30'h0BAD_BEEF;
        tick();
        a_valid_i = 1'b0;
        chk1("wd_issue", req_valid_o, 1'b1);
`ifdef ROUTER_REQ_TIMEOUT_EN
        for (int r = 0; r < MAX_RETRY; r++) begin
            cnt = 0;
            tick();
            cnt++;
            while (cnt < 60 && !req_valid_o && !drop_o) begin
                tick();
                cnt++;
            end
            if (r < MAX_RETRY - 1) begin
                chki("wd_reissue_gap", cnt, TIMEOUT + BACKOFF + 1);
                chk1("wd_reissue", req_valid_o, 1'b1);
            end else begin
                chki("wd_drop_gap", cnt, TIMEOUT + 1);
                chk1("wd_drop", drop_o, 1'b1);
                chk1("wd_drop_busy", busy_o, 1'b0);
            end
        end
        tick();
        chk1("wd_drop_single", drop_o, 1'b0);
`else
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (req_valid_o || drop_o) seen++;
        end
        chki("no_watchdog", seen, 0);
        chk1("wait_persists", busy_o, 1'b1);
        rst = 1'b1;
        tick();
        check_zero("rst_wait");
        rst = 1'b0;
        tick();
        chk1("rst_wait_ready", a_ready_o, 1'b1);
`endif

        // reset while delivering
        chk1("rd_ready", a_ready_o, 1'b1);
        a_valid_i = 1'b1; a_data_i = 30'h1357_9BDF;
        tick();
        a_valid_i = 1'b0;
        tick();
        dec_valid_i = 1'b1; dec_i = 3'b001;
        tick();
        dec_valid_i = 1'b0;
        chk1("rd_gnt_valid", gnt_valid_o, 1'b1);
        chkw("rd_gnt_data", gnt_data_o, 30'h1357_9BDF);
        rst = 1'b1;
        tick();
        check_zero("rst_deliver");
        rst = 1'b0;
        tick();
        chk1("rd_drop", drop_o, 1'b0);
        dec_q = '{3}; stall_fix = 1;
        run_txn(1'b1, 1'b1, 30'h0246_8ACE, 30'h3579_BDF1);

        stall_fix = -1;
        for (int i = 0; i < 40; i++) begin
            va = 1'($urandom);
            vb = 1'($urandom);
            if (!va && !vb) va = 1'b1;
            run_txn(va, vb, W'($urandom), W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/router_req_issuer.md
# router_req_issuer

Sequential initiator that feeds the combinational two-group route-decision logic. It accepts route-request words from two upstream ports, A and B, and presents them to the decision logic as one paired request. It samples the 3-bit decision and delivers granted requests downstream one at a time. Requests that are refused are backed off and retried; a pair that exhausts its retries is dropped.

## Interface
Parameters:
- W, 30: width of one request word (one port group).
- MAX_RETRY, 3: retry decisions tolerated before drop.
- BACKOFF, 4: idle cycles between a retry decision and re-issue (≥1).
- TIMEOUT, 16: WAIT-state cycle limit (used only with the macro).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid_i / b_valid_i  in  1  upstream port A/B request valid.
- a_data_i / b_data_i  in  W  upstream port A/B request word.
- a_ready_o / b_ready_o  out  1  capture enable, port A/B.
- req_a_o / req_b_o  out  W  words presented to decision logic; zero when the port is not pending.
- req_valid_o  out  1  one-cycle issue strobe.
- dec_valid_i  in  1  decision valid.
- dec_i  in  3  bit0 grant A, bit1 grant B, bit2 retry.
- gnt_valid_o  out  1  granted word available.
- gnt_port_o  out  1  0=A, 1=B.
- gnt_data_o  out  W  granted word.
- gnt_ready_i  in  1  downstream accept.
- drop_o  out  1  one-cycle pulse when a pair is discarded.
- busy_o  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, BACKOFF, DELIVER.
- IDLE
  - a_ready_o = b_ready_o = 1.
  - Any valid captures the port(s) whose valid is high and sets their pending flags.
  - If both are valid in the same cycle, both are captured.
  - Next state is ISSUE.
- ISSUE
  - req_valid_o = 1 for exactly one cycle.
  - req_a_o and req_b_o hold steady through WAIT.
  - Next state is WAIT.
- WAIT: on dec_valid_i, evaluate the decision.
  - A grant bit counts only if its port is pending; grants to non-pending ports are ignored.
  - Any effective grant goes to DELIVER. retry_cnt clears to 0. Bit2 is ignored in this case.
  - No effective grant (bit2 set or all zero) counts as a retry. retry_cnt increments.
  - If the incremented count equals MAX_RETRY: clear both pending flags, pulse drop_o, go to IDLE.
  - Otherwise go to BACKOFF.
- BACKOFF: count BACKOFF cycles, then go to ISSUE with the same pending set.
- DELIVER
  - Present granted ports in order, A before B.
  - gnt_valid_o is held with stable data until gnt_ready_i. Each accept clears that port's pending flag.
  - After the last granted port is accepted: if an ungranted port is still pending, go to ISSUE; otherwise go to IDLE.
- dec_valid_i outside WAIT is ignored.
- retry_cnt is 2 bits wide minimum (sized to hold MAX_RETRY). It clears on capture in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, pending flags and counters 0. IDLE ready outputs go high the first cycle after rst deasserts.
- Reset mid-operation discards the held pair. No drop_o pulse is generated.
- Minimum latency, taking the capture edge as cycle 0:
  - req_valid_o high in cycle 1.
  - dec_valid_i accepted from cycle 2 (first WAIT cycle).
  - gnt_valid_o high the cycle after the decision.
- Double grant: A is delivered first; B is presented the cycle after A's handshake.
- Retry path: from the retry decision to the next req_valid_o is BACKOFF+1 cycles.
- A simultaneous dec_valid_i and TIMEOUT expiry resolves in favour of the decision.

## Configuration
- ROUTER_REQ_TIMEOUT_EN defined:
  - A WAIT watchdog counts cycles without dec_valid_i.
  - On reaching TIMEOUT, it behaves exactly as a retry decision (retry_cnt increment, BACKOFF or drop).
- Undefined: no watchdog. WAIT persists until dec_valid_i. TIMEOUT is unused.

## Test plan
- Single A request, word 0x2AAAAAAA:
  - req_valid_o in cycle 1 with req_b_o = 0.
  - dec_i = 3'b001 in cycle 2.
  - gnt_valid_o in cycle 3 with gnt_port_o = 0 and the word unchanged; return to IDLE.
- Both ports valid, dec_i = 3'b011 with gnt_ready_i held low for 3 cycles:
  - A is held stable for 3 cycles, then delivered.
  - B is delivered next cycle.
  - Exactly two grants, no drop.
- Both ports pending, dec_i = 3'b010:
  - B is delivered.
  - Re-issue with req_b_o = 0 and req_a_o unchanged.
  - Next dec_i = 3'b001 delivers A.
- dec_i = 3'b100 three times (MAX_RETRY = 3):
  - Re-issues occur 5 cycles after each of the first two decisions.
  - drop_o pulses once after the third; busy_o falls.
- With ROUTER_REQ_TIMEOUT_EN, no dec_valid_i:
  - A retry is triggered after 16 WAIT cycles.
  - Drop after 3 timeouts.
- rst asserted in DELIVER: all outputs 0 next cycle, no drop_o; a fresh request then proceeds normally.
